// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared FSM encodings, arbitration modes and width helper for the Wishbone arbiter
package wb_arb_pkg;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: one-hot pick of the first set request bit scanning upward from base, wrapping at N
module rr_priority_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt
);
  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;
  logic [N-1:0]   rot;
  logic [N-1:0]   lo;
  // rotate so base sits at bit 0, isolate the lowest set bit, then rotate back
  always_comb begin
    dbl_req = {req, req} >> base;
    rot     = dbl_req[N-1:0];
    lo      = rot & (~rot + N'(1));
    dbl_gnt = {lo, lo} << base;
    gnt     = dbl_gnt[2*N-1:N];
  end
endmodule

// File: rtl/wb_multi_arbiter.sv
// wb_multi_arbiter: N-master Wishbone arbiter with registered one-hot grant, fixed/RR priority and beat limit
module wb_multi_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DATA_W / 8,
  parameter int RR_MODE   = 1,
  parameter int MAX_BEATS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_cyc_i,
  input  logic [N_MASTERS-1:0]        m_stb_i,
  input  logic [N_MASTERS-1:0]        m_we_i,
  input  logic [N_MASTERS*SEL_W-1:0]  m_sel_i,
  input  logic [N_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [N_MASTERS*DATA_W-1:0] m_dat_i,
  output logic [N_MASTERS-1:0]        m_ack_o,
  output logic [DATA_W-1:0]           m_dat_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [SEL_W-1:0]            s_sel_o,
  output logic [ADDR_W-1:0]           s_adr_o,
  output logic [DATA_W-1:0]           s_dat_o,
  input  logic                        s_ack_i,
  input  logic [DATA_W-1:0]           s_dat_i,
  output logic [N_MASTERS-1:0]        grant_o
);
  localparam int IW = clog2_min1(N_MASTERS);
  localparam int BW = clog2_min1(MAX_BEATS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_MASTERS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

  logic [0:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [N_MASTERS-1:0] req, pick;
  logic [IW-1:0]        owner, pick_base;
  logic                 rel;

  assign req = m_cyc_i & m_stb_i;

  rr_priority_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req  (req),
    .base (pick_base),
    .gnt  (pick)
  );

  // one-hot AND-OR muxes; grant is all zeros in IDLE, which parks the slave side at 0
  always_comb begin
    owner   = '0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      owner   = owner | (grant_q[k] ? IW'(k) : '0);
      s_sel_o = s_sel_o | (m_sel_i[k*SEL_W +: SEL_W] & {SEL_W{grant_q[k]}});
      s_adr_o = s_adr_o | (m_adr_i[k*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[k]}});
      s_dat_o = s_dat_o | (m_dat_i[k*DATA_W +: DATA_W] & {DATA_W{grant_q[k]}});
    end
  end

  assign s_cyc_o = |(m_cyc_i & grant_q);
  assign s_stb_o = |(m_stb_i & grant_q);
  assign s_we_o  = |(m_we_i & grant_q);
  assign m_ack_o = grant_q & {N_MASTERS{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  // arbitration, release and beat counting
  always_comb begin
    pick_base  = (RR_MODE == ARB_RR) ? ((last_q == LAST_IDX) ? '0 : last_q + IW'(1)) : '0;
    rel        = (state_q == OWNED) && (!s_cyc_o || ((MAX_BEATS != 0) && s_ack_i && beat_cnt_q == LAST_BEAT));
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d    = OWNED;
        grant_d    = pick;
        beat_cnt_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = owner;
    end else if (s_ack_i && beat_cnt_q != '1) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
    end
  end

  // state registers; reset parks the bus so master 0 wins the first RR round
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LAST_IDX;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_multi_arbiter.sv
// tb_wb_multi_arbiter: table-driven check of an RR (MAX_BEATS=2) and a fixed-priority (MAX_BEATS=4) arbiter
module tb_wb_multi_arbiter;
  typedef struct packed {
    logic       rst;
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack;
    logic [2:0] e_gnt;
    logic [2:0] e_mack;
    logic       e_scyc;
    logic       e_sstb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, ack_a, ack_b;
  logic [2:0]  cyc_a, stb_a, cyc_b, stb_b;
  logic [2:0]  m_we;
  logic [5:0]  m_sel;
  logic [47:0] m_adr, m_dat;
  logic [15:0] s_dat;
  logic [2:0]  mack_a, gnt_a, mack_b, gnt_b;
  logic [15:0] mdat_a, mdat_b, sdat_a, sdat_b, sadr_a, sadr_b;
  logic [1:0]  ssel_a, ssel_b;
  logic        scyc_a, sstb_a, swe_a, scyc_b, sstb_b, swe_b;
  logic [15:0] adr_t [3];
  logic [15:0] dat_t [3];
  logic [1:0]  sel_t [3];
  vec_t        va [24];
  vec_t        vb [15];
  int          n_vec = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_multi_arbiter #(.N_MASTERS(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(1), .MAX_BEATS(2)) dut_a (
    .clk(clk), .rst(rst_a), .m_cyc_i(cyc_a), .m_stb_i(stb_a), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_ack_o(mack_a), .m_dat_o(mdat_a), .s_cyc_o(scyc_a),
    .s_stb_o(sstb_a), .s_we_o(swe_a), .s_sel_o(ssel_a), .s_adr_o(sadr_a), .s_dat_o(sdat_a),
    .s_ack_i(ack_a), .s_dat_i(s_dat), .grant_o(gnt_a));

  wb_multi_arbiter #(.N_MASTERS(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(0), .MAX_BEATS(4)) dut_b (
    .clk(clk), .rst(rst_b), .m_cyc_i(cyc_b), .m_stb_i(stb_b), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_ack_o(mack_b), .m_dat_o(mdat_b), .s_cyc_o(scyc_b),
    .s_stb_o(sstb_b), .s_we_o(swe_b), .s_sel_o(ssel_b), .s_adr_o(sadr_b), .s_dat_o(sdat_b),
    .s_ack_i(ack_b), .s_dat_i(s_dat), .grant_o(gnt_b));

  function automatic vec_t mk(logic r, logic [2:0] c, logic [2:0] s, logic a,
                              logic [2:0] g, logic [2:0] ma, logic sc, logic ss);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
    v.e_gnt = g; v.e_mack = ma; v.e_scyc = sc; v.e_sstb = ss;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit b, input int idx);
    logic [2:0]  g, ma;
    logic        sc, ss, we, ewe;
    logic [1:0]  sel, esel;
    logic [15:0] adr, dat, md, eadr, edat;
    @(negedge clk);
    if (b) begin
      rst_b = v.rst; cyc_b = v.cyc; stb_b = v.stb; ack_b = v.ack;
    end else begin
      rst_a = v.rst; cyc_a = v.cyc; stb_a = v.stb; ack_a = v.ack;
    end
    s_dat = 16'h5A00 + 16'(idx) + (b ? 16'h0080 : 16'h0000);
    #1;
    g   = b ? gnt_b  : gnt_a;
    ma  = b ? mack_b : mack_a;
    sc  = b ? scyc_b : scyc_a;
    ss  = b ? sstb_b : sstb_a;
    we  = b ? swe_b  : swe_a;
    sel = b ? ssel_b : ssel_a;
    adr = b ? sadr_b : sadr_a;
    dat = b ? sdat_b : sdat_a;
    md  = b ? mdat_b : mdat_a;
    ewe = 1'b0; esel = '0; eadr = '0; edat = '0;
    for (int k = 0; k < 3; k++) if (v.e_gnt[k]) begin
      ewe = (k == 1); esel = sel_t[k]; eadr = adr_t[k]; edat = dat_t[k];
    end
    n_vec++;
    if ({g, ma, sc, ss, we, sel, adr, dat, md} !==
        {v.e_gnt, v.e_mack, v.e_scyc, v.e_sstb, ewe, esel, eadr, edat, s_dat}) begin
      n_fail++;
      $display("FAIL %s[%0d]: got gnt=%b ack=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdat=%h; want gnt=%b ack=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdat=%h",
               b ? "fixed" : "rr", idx, g, ma, sc, ss, we, sel, adr, dat, md,
               v.e_gnt, v.e_mack, v.e_scyc, v.e_sstb, ewe, esel, eadr, edat, s_dat);
    end
  endtask

  initial begin
    int beats, other;
    adr_t = '{16'h1100, 16'h2200, 16'h3300};
    dat_t = '{16'hA000, 16'hA001, 16'hA002};
    sel_t = '{2'd1, 2'd2, 2'd3};
    m_we  = 3'b010;
    m_sel = {sel_t[2], sel_t[1], sel_t[0]};
    m_adr = {adr_t[2], adr_t[1], adr_t[0]};
    m_dat = {dat_t[2], dat_t[1], dat_t[0]};
    s_dat = '0;
    rst_a = 1'b1; rst_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    cyc_a = '0; stb_a = '0; cyc_b = '0; stb_b = '0;
    // RR, MAX_BEATS=2: rotation 0,1,2,0, forced release, abort, ack on drop, reset mid-tenure
    va[0]  = mk(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    va[1]  = mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0, 0);
    va[2]  = mk(0, 3'b111, 3'b111, 0, 3'b001, 3'b000, 1, 1);
    va[3]  = mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 1, 1);
    va[4]  = mk(0, 3'b111, 3'b111, 1, 3'b001, 3'b001, 1, 1);
    va[5]  = mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0, 0);
    va[6]  = mk(0, 3'b111, 3'b111, 1, 3'b010, 3'b010, 1, 1);
    va[7]  = mk(0, 3'b111, 3'b111, 0, 3'b010, 3'b000, 1, 1);
    va[8]  = mk(0, 3'b111, 3'b111, 1, 3'b010, 3'b010, 1, 1);
    va[9]  = mk(0, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    va[10] = mk(0, 3'b111, 3'b111, 1, 3'b100, 3'b100, 1, 1);
    va[11] = mk(0, 3'b111, 3'b111, 1, 3'b100, 3'b100, 1, 1);
    va[12] = mk(0, 3'b111, 3'b111, 0, 3'b000, 3'b000, 0, 0);
    va[13] = mk(0, 3'b110, 3'b111, 0, 3'b001, 3'b000, 0, 1);
    va[14] = mk(0, 3'b110, 3'b110, 0, 3'b000, 3'b000, 0, 0);
    va[15] = mk(0, 3'b110, 3'b110, 0, 3'b010, 3'b000, 1, 1);
    va[16] = mk(0, 3'b100, 3'b100, 1, 3'b010, 3'b010, 0, 0);
    va[17] = mk(0, 3'b100, 3'b100, 0, 3'b000, 3'b000, 0, 0);
    va[18] = mk(1, 3'b100, 3'b100, 0, 3'b100, 3'b000, 1, 1);
    va[19] = mk(0, 3'b111, 3'b111, 1, 3'b000, 3'b000, 0, 0);
    va[20] = mk(0, 3'b111, 3'b111, 0, 3'b001, 3'b000, 1, 1);
    va[21] = mk(0, 3'b000, 3'b000, 0, 3'b001, 3'b000, 0, 0);
    va[22] = mk(0, 3'b001, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    va[23] = mk(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    // fixed, MAX_BEATS=4: masters 0 and 2 together, forced release after 4 acks, master 0 re-wins
    vb[0]  = mk(0, 3'b101, 3'b101, 0, 3'b000, 3'b000, 0, 0);
    vb[1]  = mk(0, 3'b101, 3'b101, 1, 3'b001, 3'b001, 1, 1);
    vb[2]  = mk(0, 3'b101, 3'b101, 1, 3'b001, 3'b001, 1, 1);
    vb[3]  = mk(0, 3'b101, 3'b101, 0, 3'b001, 3'b000, 1, 1);
    vb[4]  = mk(0, 3'b101, 3'b101, 1, 3'b001, 3'b001, 1, 1);
    vb[5]  = mk(0, 3'b101, 3'b101, 1, 3'b001, 3'b001, 1, 1);
    vb[6]  = mk(0, 3'b101, 3'b101, 0, 3'b000, 3'b000, 0, 0);
    vb[7]  = mk(0, 3'b100, 3'b100, 0, 3'b001, 3'b000, 0, 0);
    vb[8]  = mk(0, 3'b100, 3'b100, 0, 3'b000, 3'b000, 0, 0);
    vb[9]  = mk(0, 3'b100, 3'b100, 1, 3'b100, 3'b100, 1, 1);
    vb[10] = mk(0, 3'b000, 3'b000, 0, 3'b100, 3'b000, 0, 0);
    vb[11] = mk(0, 3'b110, 3'b110, 0, 3'b000, 3'b000, 0, 0);
    vb[12] = mk(0, 3'b110, 3'b110, 0, 3'b010, 3'b000, 1, 1);
    vb[13] = mk(0, 3'b000, 3'b000, 0, 3'b010, 3'b000, 0, 0);
    vb[14] = mk(0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 24; i++) apply(va[i], 1'b0, i);
    for (int i = 0; i < 15; i++) apply(vb[i], 1'b1, i);
    // single master 1, three beats with the slave acking every second cycle, then CYC drops
    @(negedge clk);
    cyc_b = 3'b010; stb_b = 3'b010; ack_b = 1'b0;
    @(negedge clk);
    #1;
    chk("single_grant", 16'(gnt_b), 16'(3'b010));
    beats = 0; other = 0;
    for (int c = 0; c < 12 && beats < 3; c++) begin
      @(negedge clk);
      ack_b = c[0];
      #1;
      if (mack_b[1]) beats++;
      if (mack_b[0] | mack_b[2]) other++;
    end
    chk("single_beats", 16'(beats), 16'd3);
    chk("single_other_ack", 16'(other), 16'd0);
    @(negedge clk);
    cyc_b = '0; stb_b = '0; ack_b = 1'b0;
    #1;
    chk("single_drop_cyc", 16'(scyc_b), 16'd0);
    @(negedge clk);
    #1;
    chk("single_release", 16'(gnt_b), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_multi_arbiter.md
# wb_multi_arbiter

Parametrised N-master Wishbone arbiter that shares one slave port, the SDRAM controller, among the CPU, the DMA engine and further bus masters. It succeeds the fixed two-master CPU/DMA arbiter with these additions:

- a registered one-hot grant;
- selectable fixed or round-robin priority;
- bus locking for multi-beat cycles while CYC stays high;
- a beat limit that forces fairness.

It sits between the masters and the SDRAM controller in the user project area.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of masters. Index 0 is the highest fixed priority. Legal range is 2–8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `SEL_W`, default `DATA_W/8`: byte-select width.
- `RR_MODE`, default 1: 0 selects fixed priority, 1 selects round-robin.
- `MAX_BEATS`, default 8: number of acked beats before the grant is forcibly released. 0 means unlimited.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `m_cyc_i`  in  N_MASTERS: per-master CYC.
- `m_stb_i`  in  N_MASTERS: per-master STB.
- `m_we_i`  in  N_MASTERS: per-master WE.
- `m_sel_i`  in  N_MASTERS*SEL_W: packed byte selects. Master k occupies `[k*SEL_W +: SEL_W]`.
- `m_adr_i`  in  N_MASTERS*ADDR_W: packed addresses, same packing.
- `m_dat_i`  in  N_MASTERS*DATA_W: packed write data, same packing.
- `m_ack_o`  out  N_MASTERS: per-master ACK.
- `m_dat_o`  out  DATA_W: read data, broadcast to all masters.
- `s_cyc_o`  out  1: slave-side CYC.
- `s_stb_o`  out  1: slave-side STB.
- `s_we_o`  out  1: slave-side WE.
- `s_sel_o`  out  SEL_W: slave-side byte select.
- `s_adr_o`  out  ADDR_W: slave-side address.
- `s_dat_o`  out  DATA_W: slave-side write data.
- `s_ack_i`  in  1: slave ACK.
- `s_dat_i`  in  DATA_W: slave read data.
- `grant_o`  out  N_MASTERS: registered one-hot grant. All zeros when idle.

## Operation
- A request from master k is `m_cyc_i[k] & m_stb_i[k]`.
- The FSM has two states, IDLE and OWNED.
- **IDLE:**
  - If any request is present, the winner is registered into `grant_o`, `beat_cnt` clears, and the next state is OWNED.
  - If no request is present, the FSM stays in IDLE.
- **Winner selection:**
  - Fixed mode: the lowest requesting index wins.
  - RR mode: the first requester found scanning from `last+1` upward, modulo `N_MASTERS`, wins. `last` is the most recently granted index.
- **OWNED, slave-side outputs:** all `s_*` outputs combinationally follow the owner's inputs.
- **OWNED, acknowledge:**
  - `m_ack_o[owner] = s_ack_i`.
  - Every other `m_ack_o` bit is 0.
- **OWNED, beat counting:** `beat_cnt` increments on each `s_ack_i`. Its width is `clog2(MAX_BEATS+1)`, minimum 1, and it saturates.
- **Release:** the FSM returns to IDLE when either condition below holds. On release, `grant_o` clears and `last` is set to the owner.
  - (a) `m_cyc_i[owner]` is 0. The owner ends or aborts its cycle.
  - (b) `MAX_BEATS != 0`, `s_ack_i` is 1, and `beat_cnt == MAX_BEATS-1`.
- **Re-arbitration:** a master that keeps CYC high after a forced release competes again in IDLE. In RR mode it loses to any other requester.
- **Bus parked (IDLE):**
  - `s_cyc_o = s_stb_o = s_we_o = 0`.
  - `s_sel_o`, `s_adr_o` and `s_dat_o` are 0.
  - All `m_ack_o` bits are 0.
- `m_dat_o = s_dat_i` at all times.
- An `s_ack_i` that arrives while in IDLE is ignored and is not forwarded.
- **Reset:** the FSM goes to IDLE, `grant_o` and `beat_cnt` clear, and `last = N_MASTERS-1`, so master 0 wins the first RR round.
  - Reset takes effect mid-transaction.
  - `s_cyc_o` drops in the cycle after `rst` is sampled high.

## Timing
- Arbitration latency is exactly 1 cycle. A request sampled in IDLE at edge t gives `grant_o` and `s_stb_o` high after edge t.
- The ACK path is combinational, with zero added latency from `s_ack_i` to `m_ack_o`.
- A release costs one dead IDLE cycle. Back-to-back owners are therefore separated by at least one cycle with `s_cyc_o` low.
- Simultaneous events within one cycle:
  - If the owner drops CYC in the same cycle as an ACK, the ACK is still forwarded, then the grant releases.
  - If a new request arrives in the release cycle, it is not considered until the following IDLE cycle.
- The grant never changes while `s_cyc_o` is high, except through reset.

## Structure
- Shared package `wb_arb_pkg`:
  - state encoding constants: IDLE = 1'b0, OWNED = 1'b1;
  - mode constants `ARB_FIXED` and `ARB_RR`.
- One sub-module, `rr_priority_pick`: a combinational request-vector and base-index to one-hot winner selector, parametrised by N. Fixed mode uses it with the base tied to 0.
- The top level holds the FSM, the grant and `last` registers, `beat_cnt`, and the one-hot-indexed muxes.

## Test plan
- **Single master:** N=2, RR. Master 1 requests for 3 beats with slave ACK on every 2nd cycle and then drops CYC.
  - `grant_o`=2'b10 one cycle after the request.
  - Exactly 3 `m_ack_o[1]` pulses, and `m_ack_o[0]` stays 0.
  - `grant_o` returns to 0 the cycle after CYC drops.
- **Simultaneous requests, fixed mode:** N=3, fixed mode, masters 0 and 2 request at once.
  - Master 0 is served first and master 2 afterwards.
  - There is one idle cycle between the two owners.
- **Simultaneous requests, RR mode:** N=3, RR, all three masters request continuously with `MAX_BEATS`=2.
  - Grant sequence is 0,1,2,0.
  - Each tenure has exactly 2 ACKs.
- **Forced release:** `MAX_BEATS`=4, master 0 holds CYC for 10 beats while master 1 requests.
  - Master 0 is released after its 4th ACK.
  - Master 1 is granted in the next arbitration.
- **Abort:** the owner drops CYC with STB pending and no ACK.
  - `s_cyc_o` goes to 0 in the same cycle.
  - IDLE on the next edge, with `last` updated.
- **Reset mid-transfer:** `rst` is pulsed during an OWNED beat.
  - `s_cyc_o`, `grant_o` and `m_ack_o` are all 0 on the next edge.
  - The next RR arbitration picks master 0.
